// File: rtl/simd_rf_pkg.sv
// simd_rf_pkg: shared constants and lane-mask helper for the SIMD FP register file write path
package simd_rf_pkg;

    localparam int simd_rf_lanes_gp = 4;
    localparam int simd_rf_rows_gp  = 8;

    // simd writes the whole row; a scalar write enables only its own lane
    function automatic logic [simd_rf_lanes_gp-1:0] lane_mask(input logic [1:0] lane, input logic simd);
        return simd ? '1 : 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/simd_rf_wreq_fifo.sv
// simd_rf_wreq_fifo: two-pointer circular buffer of write requests
//   clk_i, reset_i : clock, asynchronous active-high reset
//   enq_i, data_i  : push (caller guarantees not full)
//   deq_i, data_o  : pop (caller guarantees not empty), head element
//   full_o, empty_o, count_o : occupancy
module simd_rf_wreq_fifo #(
    parameter type elem_t = logic,
    parameter int  els_p  = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         enq_i,
    input  elem_t                        data_i,
    input  logic                         deq_i,
    output elem_t                        data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int cnt_w = $clog2(els_p + 1);
    localparam int ptr_w = $clog2(els_p);
    localparam logic [ptr_w-1:0] last = ptr_w'(els_p - 1);

    elem_t mem [els_p];
    logic [ptr_w-1:0] wp, rp;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wp      <= '0;
            rp      <= '0;
            count_o <= '0;
        end else begin
            if (enq_i) wp <= (wp == last) ? '0 : wp + 1'b1;
            if (deq_i) rp <= (rp == last) ? '0 : rp + 1'b1;
            count_o <= count_o + cnt_w'(enq_i) - cnt_w'(deq_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_i) mem[wp] <= data_i;
    end

    assign data_o  = mem[rp];
    assign full_o  = count_o == cnt_w'(els_p);
    assign empty_o = count_o == '0;

endmodule

// File: rtl/simd_rf_write_arbiter.sv
// simd_rf_write_arbiter: shares the regfile row write port between pipeline writeback and buffered load returns
//   clk_i, reset_i                      : clock, asynchronous active-high reset
//   wb_v_i/wb_ready_o, wb_addr_i,
//   wb_simd_i, wb_data_i                : source 0, granted in the cycle it is accepted
//   ld_v_i/ld_ready_o, ld_addr_i,
//   ld_simd_i, ld_data_i                : source 1, always enqueued before being written
//   w_v_o, w_addr_o, w_data_o           : registered regfile write (lane enables, row address, lane data)
//   ld_pending_o                        : a source-1 write is buffered or sitting in the output register
module simd_rf_write_arbiter
    import simd_rf_pkg::*;
#(
    parameter int width_p        = 32,
    parameter int els_p          = 32,
    parameter int fifo_els_p     = 2,
    parameter int starve_limit_p = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          wb_v_i,
    output logic                          wb_ready_o,
    input  logic [4:0]                    wb_addr_i,
    input  logic                          wb_simd_i,
    input  logic [4*width_p-1:0]          wb_data_i,
    input  logic                          ld_v_i,
    output logic                          ld_ready_o,
    input  logic [4:0]                    ld_addr_i,
    input  logic                          ld_simd_i,
    input  logic [4*width_p-1:0]          ld_data_i,
    output logic [simd_rf_lanes_gp-1:0]   w_v_o,
    output logic [4:0]                    w_addr_o,
    output logic [4*width_p-1:0]          w_data_o,
    output logic                          ld_pending_o
);

    if (els_p != simd_rf_lanes_gp * simd_rf_rows_gp) begin : g_els_chk
        $error("els_p must be 32");
    end
    if (fifo_els_p < 2) begin : g_fifo_chk
        $error("fifo_els_p must be at least 2");
    end
    if (starve_limit_p < 1) begin : g_starve_chk
        $error("starve_limit_p must be at least 1");
    end

    typedef struct packed {
        logic [4:0]                                 addr;
        logic                                       simd;
        logic [simd_rf_lanes_gp-1:0][width_p-1:0]   data;
    } simd_rf_wreq_s;

    localparam int cnt_w = $clog2(fifo_els_p + 1);
    localparam int stv_w = $clog2(starve_limit_p + 1);
    localparam logic [stv_w-1:0] stv_lim = stv_w'(starve_limit_p);

    simd_rf_wreq_s ld_req, head;
    logic full, empty, hv, enq, deq, wb_fire, merge, starve_r;
    logic [cnt_w-1:0] fifo_cnt, fifo_cnt_n;
    logic [stv_w-1:0] stv_cnt, stv_cnt_n;
    logic [simd_rf_lanes_gp-1:0] wb_mask, hd_mask, v_n;
    logic [4:0] addr_n;
    logic [simd_rf_lanes_gp-1:0][width_p-1:0] wb_lanes, data_n;

    assign ld_req     = {ld_addr_i, ld_simd_i, ld_data_i};
    assign wb_lanes   = wb_data_i;
    assign ld_ready_o = ~full;
    assign wb_ready_o = ~starve_r;
    assign enq        = ld_v_i & ~full;
    assign hv         = ~empty;

    simd_rf_wreq_fifo #(
        .elem_t (simd_rf_wreq_s),
        .els_p  (fifo_els_p)
    ) fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .enq_i   (enq),
        .data_i  (ld_req),
        .deq_i   (deq),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        wb_fire = wb_v_i & ~starve_r;
        wb_mask = wb_fire ? lane_mask(wb_addr_i[1:0], wb_simd_i) : '0;
        hd_mask = hv ? lane_mask(head.addr[1:0], head.simd) : '0;
        // head rides along with an accepted wb only on the same row with no shared lane
        merge = wb_fire & hv & (wb_addr_i[4:2] == head.addr[4:2]) & ~|(wb_mask & hd_mask);
        deq = hv & (~wb_fire | merge);
        v_n = wb_mask | (deq ? hd_mask : '0);
        addr_n = {wb_fire ? wb_addr_i[4:2] : head.addr[4:2], 2'b00};
        for (int l = 0; l < simd_rf_lanes_gp; l++)
            data_n[l] = (deq & hd_mask[l]) ? head.data[l] : wb_lanes[l];
        stv_cnt_n = (~hv | deq) ? '0 : (stv_cnt == stv_lim) ? stv_cnt : stv_cnt + 1'b1;
        fifo_cnt_n = fifo_cnt + cnt_w'(enq) - cnt_w'(deq);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            w_v_o        <= '0;
            w_addr_o     <= '0;
            w_data_o     <= '0;
            stv_cnt      <= '0;
            starve_r     <= 1'b0;
            ld_pending_o <= 1'b0;
        end else begin
            w_v_o        <= v_n;
            w_addr_o     <= addr_n;
            w_data_o     <= data_n;
            stv_cnt      <= stv_cnt_n;
            // block source 0 for the cycle after the head has waited its limit
            starve_r     <= stv_cnt_n == stv_lim;
            ld_pending_o <= (fifo_cnt_n != '0) | deq;
        end
    end

endmodule

// File: tb/tb_simd_rf_write_arbiter.sv
// tb_simd_rf_write_arbiter: directed scoreboard bench for the regfile write arbiter
module tb_simd_rf_write_arbiter;

    localparam int W = 16;

    typedef struct packed {
        logic [3:0]     v;
        logic [4:0]     addr;
        logic [4*W-1:0] data;
    } wr_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           wb_v = 1'b0, wb_simd = 1'b0, ld_v = 1'b0, ld_simd = 1'b0;
    logic [4:0]     wb_addr = '0, ld_addr = '0;
    logic [4*W-1:0] wb_data = '0, ld_data = '0;
    logic           wb_ready, ld_ready, ld_pending;
    logic [3:0]     w_v;
    logic [4:0]     w_addr;
    logic [4*W-1:0] w_data;

    wr_t exp_q[$];
    int  n_chk = 0;
    int  n_fail = 0;

    simd_rf_write_arbiter #(.width_p(W), .els_p(32), .fifo_els_p(2), .starve_limit_p(4)) dut (
        .clk_i(clk), .reset_i(reset),
        .wb_v_i(wb_v), .wb_ready_o(wb_ready), .wb_addr_i(wb_addr), .wb_simd_i(wb_simd), .wb_data_i(wb_data),
        .ld_v_i(ld_v), .ld_ready_o(ld_ready), .ld_addr_i(ld_addr), .ld_simd_i(ld_simd), .ld_data_i(ld_data),
        .w_v_o(w_v), .w_addr_o(w_addr), .w_data_o(w_data), .ld_pending_o(ld_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*W-1:0] lmask(input logic [3:0] v);
        logic [4*W-1:0] m;
        for (int i = 0; i < 4; i++) m[i*W +: W] = {W{v[i]}};
        return m;
    endfunction

    // one clock, then compare any regfile write against the scoreboard head
    task automatic step();
        wr_t e;
        @(posedge clk);
        #1;
        if (w_v !== 4'b0) begin
            chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("w_v", 64'(w_v), 64'(e.v));
                chk("w_addr", 64'(w_addr), 64'(e.addr));
                chk("w_data", 64'(w_data & lmask(e.v)), 64'(e.data & lmask(e.v)));
            end
        end
    endtask

    initial begin
        step();
        chk("rst_w_v", 64'(w_v), 64'd0);
        chk("rst_w_addr", 64'(w_addr), 64'd0);
        chk("rst_w_data", 64'(w_data), 64'd0);
        chk("rst_pending", 64'(ld_pending), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd1);
        chk("rst_wb_ready", 64'(wb_ready), 64'd1);
        reset = 1'b0;
        step();

        // scalar wb to register 9 -> row 8, lane 1
        wb_v = 1'b1; wb_simd = 1'b0; wb_addr = 5'd9;
        wb_data = {16'h3333, 16'h2222, 16'hAAAA, 16'h1111};
        exp_q.push_back('{v: 4'b0010, addr: 5'd8, data: {16'h0, 16'h0, 16'hAAAA, 16'h0}});
        chk("scalar_wb_ready", 64'(wb_ready), 64'd1);
        step();

        // simd wb to row 12
        wb_simd = 1'b1; wb_addr = 5'd12;
        wb_data = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
        exp_q.push_back('{v: 4'b1111, addr: 5'd12, data: {16'hC003, 16'hC002, 16'hC001, 16'hC000}});
        step();
        wb_v = 1'b0;
        step();
        chk("idle_no_write", 64'(w_v), 64'd0);

        // merge: ld lane 0 and wb lane 1 of row 16
        ld_v = 1'b1; ld_simd = 1'b0; ld_addr = 5'd16;
        ld_data = {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'h0A0A};
        step();
        ld_v = 1'b0;
        chk("merge_pend_buf", 64'(ld_pending), 64'd1);
        chk("merge_no_bypass", 64'(w_v), 64'd0);
        wb_v = 1'b1; wb_simd = 1'b0; wb_addr = 5'd17;
        wb_data = {16'hBEEF, 16'hBEEF, 16'hB1B1, 16'hBEEF};
        exp_q.push_back('{v: 4'b0011, addr: 5'd16, data: {16'h0, 16'h0, 16'hB1B1, 16'h0A0A}});
        step();
        chk("merge_pend_outreg", 64'(ld_pending), 64'd1);
        wb_v = 1'b0;
        step();
        chk("merge_pend_fall", 64'(ld_pending), 64'd0);

        // starvation: ld to row 4 while wb hammers row 0
        ld_v = 1'b1; ld_simd = 1'b0; ld_addr = 5'd4;
        ld_data = {16'h0, 16'h0, 16'h0, 16'h4444};
        wb_v = 1'b1; wb_simd = 1'b0; wb_addr = 5'd1;
        wb_data = {16'h0, 16'h0, 16'h5555, 16'h0};
        exp_q.push_back('{v: 4'b0010, addr: 5'd0, data: {16'h0, 16'h0, 16'h5555, 16'h0}});
        step();
        ld_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("starve_wb_ready_hi", 64'(wb_ready), 64'd1);
            exp_q.push_back('{v: 4'b0010, addr: 5'd0, data: {16'h0, 16'h0, 16'h5555, 16'h0}});
            step();
        end
        chk("starve_wb_ready_lo", 64'(wb_ready), 64'd0);
        exp_q.push_back('{v: 4'b0001, addr: 5'd4, data: {16'h0, 16'h0, 16'h0, 16'h4444}});
        step();
        chk("starve_wb_ready_back", 64'(wb_ready), 64'd1);
        exp_q.push_back('{v: 4'b0010, addr: 5'd0, data: {16'h0, 16'h0, 16'h5555, 16'h0}});
        step();
        wb_v = 1'b0;
        step();
        chk("starve_pend_clear", 64'(ld_pending), 64'd0);

        // three loads, no wb traffic: writes in order at t+2, t+3, t+4
        ld_v = 1'b1; ld_simd = 1'b1; ld_addr = 5'd20;
        ld_data = {16'hE103, 16'hE102, 16'hE101, 16'hE100};
        exp_q.push_back('{v: 4'b1111, addr: 5'd20, data: {16'hE103, 16'hE102, 16'hE101, 16'hE100}});
        chk("stream_ready1", 64'(ld_ready), 64'd1);
        step();
        chk("stream_lat_t1", 64'(w_v), 64'd0);
        ld_simd = 1'b0; ld_addr = 5'd25;
        ld_data = {16'h0, 16'h0, 16'hE201, 16'h0};
        exp_q.push_back('{v: 4'b0010, addr: 5'd24, data: {16'h0, 16'h0, 16'hE201, 16'h0}});
        chk("stream_ready2", 64'(ld_ready), 64'd1);
        step();
        ld_addr = 5'd31;
        ld_data = {16'hE303, 16'h0, 16'h0, 16'h0};
        exp_q.push_back('{v: 4'b1000, addr: 5'd28, data: {16'hE303, 16'h0, 16'h0, 16'h0}});
        chk("stream_ready3", 64'(ld_ready), 64'd1);
        step();
        ld_v = 1'b0;
        step();
        chk("stream_drained", 64'(exp_q.size()), 64'd0);
        step();

        // fill the buffer behind overlapping simd wb writes, then reset mid-cycle
        wb_v = 1'b1; wb_simd = 1'b1; wb_addr = 5'd8;
        wb_data = {16'h7777, 16'h6666, 16'h5555, 16'h4444};
        ld_v = 1'b1; ld_simd = 1'b0; ld_addr = 5'd8;
        ld_data = {16'h0, 16'h0, 16'h0, 16'hF0F0};
        exp_q.push_back('{v: 4'b1111, addr: 5'd8, data: {16'h7777, 16'h6666, 16'h5555, 16'h4444}});
        step();
        ld_addr = 5'd9;
        ld_data = {16'h0, 16'h0, 16'hF1F1, 16'h0};
        exp_q.push_back('{v: 4'b1111, addr: 5'd8, data: {16'h7777, 16'h6666, 16'h5555, 16'h4444}});
        step();
        ld_v = 1'b0;
        chk("full_ld_ready", 64'(ld_ready), 64'd0);
        exp_q.push_back('{v: 4'b1111, addr: 5'd8, data: {16'h7777, 16'h6666, 16'h5555, 16'h4444}});
        step();
        wb_v = 1'b0;
        chk("full_pending", 64'(ld_pending), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_w_v", 64'(w_v), 64'd0);
        chk("async_rst_pending", 64'(ld_pending), 64'd0);
        #2 reset = 1'b0;
        #1;
        chk("post_rst_ld_ready", 64'(ld_ready), 64'd1);
        chk("post_rst_wb_ready", 64'(wb_ready), 64'd1);
        for (int i = 0; i < 4; i++) step();
        chk("post_rst_no_stale", 64'(w_v), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
